queue_scheduler: RTL
====================

# queue_scheduler

Per-output-port scheduler choosing which of the 8 priority queues feeding one output port supplies the next packet. It runs strict priority (SP) or weighted round robin (WRR), per `wrr_en`, and issues one packet grant at a time to that port's read engine. The read engine walks the queue-head/jump-table chain through the SRAMs and drives `rd_sop/rd_vld/rd_eop`. One instance sits per output port inside the controller, 16 in total.

## Interface
Parameters:
- `PRIOR_NUM`, default 8: number of priority queues per port; index 0 is the highest priority.
- `WEIGHT_W`, default 4: width of each WRR weight and credit counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wrr_en`  in  1  1 = WRR, 0 = SP. Sampled only in IDLE.
- `weight`  in  PRIOR_NUM*WEIGHT_W  packets per round for queue i, in bits [i*WEIGHT_W +: WEIGHT_W]. A value of 0 is treated as 1.
- `queue_not_empty`  in  PRIOR_NUM  bit i set means queue i holds at least one packet.
- `ready`  in  1  downstream port ready.
- `grant_vld`  out  1  a grant is pending to the read engine. Reset value 0.
- `grant_prior`  out  3  queue index being granted. Reset value 0.
- `grant_ack`  in  1  read engine accepts the grant.
- `pkt_done`  in  1  one-cycle pulse when the read engine emits `rd_eop` of the granted packet.
- `busy`  out  1  high in GRANT or XFER. Reset value 0.

## Operation
- States: IDLE, RELOAD, GRANT, XFER. Reset state is IDLE. All credits reset to 0 and `rr_ptr` resets to 0.
- IDLE, when `ready`=1 and `queue_not_empty`≠0:
  - SP: select the lowest-index non-empty queue. Go to GRANT.
  - WRR, eligible queue present: eligible means non-empty with credit > 0. Select the first eligible queue scanning upward from `rr_ptr` with wrap 7→0. Go to GRANT.
  - WRR, non-empty queues but none eligible: go to RELOAD.
- IDLE, otherwise: stay in IDLE.
- RELOAD: load credit[i] = max(weight[i], 1) for every i. Return to IDLE. Lasts exactly 1 cycle.
- Mode switch SP→WRR, detected in IDLE: forces RELOAD before the first WRR grant.
- GRANT:
  - Drive `grant_vld`=1 with `grant_prior` equal to the selected queue.
  - Hold both until `grant_ack`, regardless of `ready` and `queue_not_empty`.
  - On `grant_ack`, go to XFER. In WRR mode, also credit[sel] -= 1. If the new credit is 0, `rr_ptr` = sel+1 mod 8; otherwise `rr_ptr` = sel, so the same queue is served again, up to its weight.
- XFER: wait for `pkt_done`, then go to IDLE.
  - `pkt_done` outside XFER is ignored.
  - `grant_ack` outside GRANT is ignored.
- Credits never underflow. Weights are read only in RELOAD, so changing `weight` mid-round takes effect at the next round.
- The granted queue cannot go empty before ack, because only its own read engine dequeues it. No grant retraction exists.

## Timing
- IDLE decision at cycle N: `grant_vld`=1 from cycle N+1.
- WRR path with reload: RELOAD at N, re-decision at N+1, `grant_vld` at N+2.
- `grant_ack` sampled at cycle M: `grant_vld`=0 at M+1, and the state is XFER at M+1.
- `pkt_done` at cycle K: IDLE at K+1, earliest next `grant_vld` at K+2. Back-to-back packets therefore have a 2-cycle grant gap minimum.
- `busy` is registered: it mirrors the state (GRANT or XFER) one cycle after each transition.
- `rst_n` low at any time: outputs go to reset values immediately (asynchronous). Any in-flight grant is dropped, and the read engine is reset by the same `rst_n`.

## Structure
- Shared package `sched_pkg`:
  - `PRIOR_NUM` and `WEIGHT_W` defaults.
  - `sched_state_t` enum (IDLE, RELOAD, GRANT, XFER).
  - `prior_t` typedef, `logic [2:0]`.
- Sub-module `rr_pick`: combinational 8-bit rotating priority encoder. Inputs: mask, start pointer. Outputs: index, found flag. Used for WRR selection; SP selection uses it with start pointer 0.

## Test plan
- SP, `queue_not_empty`=8'b1010_0100, `ready`=1 → `grant_prior`=2 one cycle after the IDLE decision. Ack, then `pkt_done`; with the mask unchanged, the next grant is 2 again.
- WRR, weights q0=2, q3=1, others 1, queues 0 and 3 non-empty forever:
  - The first decision enters RELOAD, so the first `grant_vld` appears at cycle N+2.
  - Grant sequence is 0,0,3,0,0,3,…
  - RELOAD occurs after each 3-packet round.
- Hold rule: `grant_ack` held low for 5 cycles, with `ready` dropping mid-wait → `grant_vld`=1 and `grant_prior` stable for all 5 cycles, cleared the cycle after ack.
- Weight 0: in WRR, all weights 0, queues 1 and 6 non-empty → grants alternate 1,6,1,6, with a RELOAD between every pair.
- Reset during XFER → `grant_vld`=0 and `busy`=0 immediately. After release, the first grant requires a fresh IDLE decision, with RELOAD first in WRR.
- Stray inputs: `pkt_done` pulsed in IDLE, and `grant_ack` pulsed in XFER → no state change and no credit change.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and defaults for the per-port queue scheduler.
package sched_pkg;

  localparam int DEF_PRIOR_NUM = 8;
  localparam int DEF_WEIGHT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RELOAD,
    GRANT,
    XFER
  } sched_state_t;

  typedef logic [2:0] prior_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set mask bit at or after start, wrapping to 0.
module rr_pick
  import sched_pkg::*;
#(
  parameter int N = DEF_PRIOR_NUM
) (
  input  logic [N-1:0] mask,
  input  prior_t       start,
  output prior_t       index,
  output logic         found
);

  function automatic prior_t wrap_add(input prior_t base, input int offs);
    return prior_t'((int'(base) + offs) % N);
  endfunction

  // Scan from the far end back toward start so the nearest hit is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    index = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[wrap_add(start, k)]) begin
        index = wrap_add(start, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_scheduler.sv
// Per-output-port SP/WRR scheduler issuing one packet grant at a time to the read engine.
module queue_scheduler
  import sched_pkg::*;
#(
  parameter int PRIOR_NUM = DEF_PRIOR_NUM,
  parameter int WEIGHT_W  = DEF_WEIGHT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wrr_en,
  input  logic [PRIOR_NUM*WEIGHT_W-1:0] weight,
  input  logic [PRIOR_NUM-1:0]          queue_not_empty,
  input  logic                          ready,
  output logic                          grant_vld,
  output prior_t                        grant_prior,
  input  logic                          grant_ack,
  input  logic                          pkt_done,
  output logic                          busy
);

  sched_state_t          state_q, state_d;
  logic [WEIGHT_W-1:0]   credit_q [PRIOR_NUM];
  prior_t                rr_ptr_q;
  logic                  mode_wrr_q;
  logic                  need_reload_q;

  logic [PRIOR_NUM-1:0]  eligible;
  prior_t                sp_idx, wrr_idx;
  logic                  sp_found, wrr_found;
  logic                  have_req;

  logic                  grant_vld_d, busy_d;
  prior_t                grant_prior_d;

  assign have_req = ready && (|queue_not_empty);

  always_comb begin
    eligible = '0;
    for (int i = 0; i < PRIOR_NUM; i++) begin
      eligible[i] = queue_not_empty[i] && (credit_q[i] != '0);
    end
  end

  rr_pick #(.N(PRIOR_NUM)) u_sp_pick (
    .mask  (queue_not_empty),
    .start ('0),
    .index (sp_idx),
    .found (sp_found)
  );

  rr_pick #(.N(PRIOR_NUM)) u_wrr_pick (
    .mask  (eligible),
    .start (rr_ptr_q),
    .index (wrr_idx),
    .found (wrr_found)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (have_req) begin
          if (!wrr_en)                          state_d = GRANT;
          else if (need_reload_q || !wrr_found) state_d = RELOAD;
          else                                  state_d = GRANT;
        end
      end
      RELOAD:  state_d = IDLE;
      GRANT:   if (grant_ack) state_d = XFER;
      XFER:    if (pkt_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    grant_vld_d   = (state_d == GRANT);
    busy_d        = (state_q == GRANT) || (state_q == XFER);
    grant_prior_d = grant_prior;
    if (state_q == IDLE && state_d == GRANT) begin
      grant_prior_d = wrr_en ? wrr_idx : (sp_found ? sp_idx : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld   <= 1'b0;
      grant_prior <= '0;
      busy        <= 1'b0;
    end else begin
      grant_vld   <= grant_vld_d;
      grant_prior <= grant_prior_d;
      busy        <= busy_d;
    end
  end

  // Credit bookkeeping; an SP idle cycle arms a reload for the next WRR decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the credit array is a handful of flops, so it is reset like any other state.
      for (int i = 0; i < PRIOR_NUM; i++) credit_q[i] <= '0;
      rr_ptr_q      <= '0;
      mode_wrr_q    <= 1'b0;
      need_reload_q <= 1'b1;
    end else begin
      if (state_q == IDLE) begin
        mode_wrr_q <= wrr_en;
        if (!wrr_en) need_reload_q <= 1'b1;
      end

      if (state_q == RELOAD) begin
        need_reload_q <= 1'b0;
        for (int i = 0; i < PRIOR_NUM; i++) begin
          credit_q[i] <= (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                         WEIGHT_W'(1) : weight[i*WEIGHT_W +: WEIGHT_W];
        end
      end

      if (state_q == GRANT && grant_ack && mode_wrr_q && credit_q[grant_prior] != '0) begin
        credit_q[grant_prior] <= credit_q[grant_prior] - WEIGHT_W'(1);
        if (credit_q[grant_prior] == WEIGHT_W'(1))
          rr_ptr_q <= prior_t'((int'(grant_prior) + 1) % PRIOR_NUM);
        else
          rr_ptr_q <= grant_prior;
      end
    end
  end

endmodule
